// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART_TX pin arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_TAPE = 2'd1,
        SRC_MIDI = 2'd2,
        SRC_UART = 2'd3
    } src_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        FIXED = 2'd2
    } state_t;

    localparam logic TX_IDLE = 1'b1;

    // Source vectors are packed {uart, midi, tape}; id 1..3 maps to bit id-1.
    function automatic logic [2:0] id_mask(input logic [1:0] id);
        logic [2:0] m;
        m = 3'b000;
        if (id != 2'd0) m[id - 2'd1] = 1'b1;
        return m;
    endfunction

    function automatic logic src_level(input logic [2:0] v, input logic [1:0] id);
        logic l;
        l = TX_IDLE;
        if (id != 2'd0) l = v[id - 2'd1];
        return l;
    endfunction

    function automatic src_id_t pick_src(input logic [2:0] e, input logic uart_first);
        src_id_t w;
        w = SRC_NONE;
        if (uart_first) begin
            if (e[2])      w = SRC_UART;
            else if (e[1]) w = SRC_MIDI;
            else if (e[0]) w = SRC_TAPE;
        end else begin
            if (e[0])      w = SRC_TAPE;
            else if (e[1]) w = SRC_MIDI;
            else if (e[2]) w = SRC_UART;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arb_edge.sv
// Per-source toggle detector; the first cycle after reset only primes the history.
module uart_tx_arb_edge
    import uart_tx_arb_pkg::*;
(
    input  logic clk_sys,
    input  logic reset_n,
    input  logic src,
    output logic edge_det
);

    logic prev_q, prev_d;
    logic prime_q, prime_d;

    always_comb begin
        prev_d  = src;
        prime_d = 1'b0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= TX_IDLE;
            prime_q <= 1'b1;
        end else begin
            prev_q  <= prev_d;
            prime_q <= prime_d;
        end
    end

    assign edge_det = !prime_q && (src != prev_q);

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART_TX pad arbiter: first toggling source owns the pin until quiet for HOLD_TICKS ce ticks.
// Optional collision counter output coll_cnt enabled by UART_TX_ARB_STATUS_EN.
//
// state | meaning
// IDLE  | no owner, tx parked high, waiting for first edge
// OWN   | grant holds owner id, tx follows owner, quiet timer running on ce
// FIXED | cfg_sel forces a source, no timeout
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int HOLD_W          = 22,
    parameter int HOLD_TICKS      = 2800000,
    parameter bit PRIO_UART_FIRST = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       src_tape,
    input  logic       src_midi,
    input  logic       src_uart,
    input  logic [1:0] cfg_sel,
    output logic       tx,
    output logic [1:0] grant,
    output logic       busy
`ifdef UART_TX_ARB_STATUS_EN
    ,
    output logic [7:0] coll_cnt
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic [2:0]        src_v;
    logic [2:0]        edge_v;
    state_t            state_q, state_d;
    src_id_t           grant_q, grant_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    src_id_t           win;
    logic [2:0]        owner_mask;
    logic              owner_edge;

    assign src_v = {src_uart, src_midi, src_tape};

    uart_tx_arb_edge u_edge_tape (.clk_sys(clk_sys), .reset_n(reset_n), .src(src_tape), .edge_det(edge_v[0]));
    uart_tx_arb_edge u_edge_midi (.clk_sys(clk_sys), .reset_n(reset_n), .src(src_midi), .edge_det(edge_v[1]));
    uart_tx_arb_edge u_edge_uart (.clk_sys(clk_sys), .reset_n(reset_n), .src(src_uart), .edge_det(edge_v[2]));

    always_comb begin
        win        = pick_src(edge_v, PRIO_UART_FIRST);
        owner_mask = id_mask(grant_q);
        owner_edge = |(edge_v & owner_mask);

        state_d = state_q;
        grant_d = grant_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;

        // A non-zero select overrides everything; edges seen this cycle are dropped.
        if (cfg_sel != 2'd0) begin
            state_d = FIXED;
            grant_d = src_id_t'(cfg_sel);
            tx_d    = src_level(src_v, cfg_sel);
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    grant_d = SRC_NONE;
                    tx_d    = TX_IDLE;
                    if (|edge_v) begin
                        state_d = OWN;
                        grant_d = win;
                        tx_d    = src_level(src_v, win);
                        cnt_d   = '0;
                    end
                end
                OWN: begin
                    tx_d = src_level(src_v, grant_q);
                    if (owner_edge) begin
                        cnt_d = '0;
                    end else if (ce) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = IDLE;
                            grant_d = SRC_NONE;
                            tx_d    = TX_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = SRC_NONE;
                    tx_d    = TX_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (grant_d != SRC_NONE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= SRC_NONE;
            tx_q    <= TX_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx    = tx_q;
    assign grant = grant_q;
    assign busy  = busy_q;

`ifdef UART_TX_ARB_STATUS_EN
    logic [7:0] coll_q, coll_d;
    logic       coll_hit;

    always_comb begin
        coll_hit = 1'b0;
        if (state_q == OWN)       coll_hit = |(edge_v & ~owner_mask);
        else if (state_q == IDLE) coll_hit = |(edge_v & ~id_mask(win));

        coll_d = coll_q;
        if (cfg_sel != 2'd0)                  coll_d = 8'd0;
        else if (coll_hit && coll_q != 8'hFF) coll_d = coll_q + 8'd1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) coll_q <= 8'd0;
        else          coll_q <= coll_d;
    end

    assign coll_cnt = coll_q;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART_TX pin between three serial-like sources: tape output, MIDI output and the UART transmitter of the tsconf core.
- Grants the pin to the first source that toggles and holds ownership until that source has been quiet for a timeout.
- Edges from non-owners are ignored (optionally counted); a fixed-select override bypasses arbitration.
- Sits between the tsconf instance and the UART_TX pad in the top level, replacing the ad-hoc edge-follow mux.

Parameters:
- HOLD_W, 22: width of the quiet-timeout counter.
- HOLD_TICKS, 2800000: ce ticks of owner inactivity before release (100 ms at a 28 MHz ce). Must be ≥2 and <2^HOLD_W.
- PRIO_UART_FIRST, 1: on simultaneous first edges, 1 gives priority uart>midi>tape; 0 gives tape>midi>uart.

Ports:
- clk_sys  in  1  system clock (84 MHz); all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  timeout tick enable (ce_28m).
- src_tape  in  1  tape output level.
- src_midi  in  1  MIDI serial out, idle-high.
- src_uart  in  1  UART TX, idle-high.
- cfg_sel  in  2  0=auto arbitration, 1=tape, 2=midi, 3=uart forced.
- tx  out  1  registered line to UART_TX pad.
- grant  out  2  current owner: 0 none, 1 tape, 2 midi, 3 uart.
- busy  out  1  high while grant≠0.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: tx=1, grant=0, busy=0.
  - Internal: prev regs=1, hold counter=0, prime=1.
- Priming: the first clk_sys after reset release loads prev regs from the src inputs. No edges are detected on that cycle; prime then clears.
- Edge detect: edge_x = src_x != prev_x, evaluated combinationally from registered prev. prev_x <= src_x every cycle.
- States: IDLE, OWN (owner id held in grant), FIXED.
- IDLE (cfg_sel=0):
  - tx holds 1.
  - On any edge, grant <= highest-priority edging source, tx <= that src value, counter <= 0, go to OWN.
  - Latency: tx follows the src change one clk_sys later.
- OWN:
  - Every cycle, tx <= src[grant].
  - Owner edge: counter <= 0.
  - Otherwise, on ce, counter +1.
  - When ce and counter == HOLD_TICKS-1 and no owner edge that cycle: grant <= 0, tx <= 1, go to IDLE.
  - An owner edge on the release cycle wins: stay in OWN, counter <= 0.
  - Non-owner edges are ignored and never preempt.
- Release and new edge in the same cycle: release takes effect; the new edge is not granted. That source is granted on its next edge.
- FIXED (cfg_sel≠0):
  - grant <= cfg_sel; tx <= selected src every cycle; counter held at 0; no timeout.
- cfg_sel changes, applied on the next clk_sys:
  - Non-zero value: go to FIXED with the new source.
  - Change to 0: go to IDLE, tx <= 1, grant <= 0.
  - Edges occurring during the switch cycle are discarded.
- Counter never wraps: it is compared and cleared before reaching 2^HOLD_W.
- busy = (grant != 0), registered together with grant.

Optional Feature:
- Macro: UART_TX_ARB_STATUS_EN.
- Defined:
  - Adds output coll_cnt [7:0], reset to 0.
  - Increments by 1 per clk_sys in which a non-owner edge occurs while in OWN.
  - Also increments on an IDLE-state edge from a lower-priority source that lost a simultaneous grant.
  - Saturates at 255; clears when cfg_sel is written to a non-zero value.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Package uart_tx_arb_pkg:
  - enum src_id_t {SRC_NONE=0, SRC_TAPE=1, SRC_MIDI=2, SRC_UART=3}.
  - enum state_t {IDLE, OWN, FIXED}.
  - Constant TX_IDLE=1'b1.
- One natural sub-module: uart_tx_arb_edge, holding the per-source prev register, priming and edge output; instantiated three times.
- Timeout counter and FSM stay in the top of the block.

Test Plan:
1. Reset, then hold all src at 1 for 10 cycles → tx=1, grant=0, busy=0, no grant from priming.
2. cfg_sel=0; toggle src_midi 1→0 → next cycle grant=2, tx=0. Then toggle src_uart → grant stays 2 and tx tracks midi (coll_cnt=1 with STATUS_EN).
3. HOLD_TICKS=4, ce every cycle; midi owner quiet → release on the 4th ce after its last edge: grant=0, tx=1.
4. src_tape and src_uart toggle in the same cycle: PRIO_UART_FIRST=1 gives grant=3; PRIO_UART_FIRST=0 gives grant=1.
5. Owner edge coincident with the terminal tick → no release, counter restarts, grant unchanged.
6. cfg_sel=1 mid-OWN(midi) → next cycle grant=1, tx follows tape, no timeout after 10·HOLD_TICKS. Then cfg_sel=0 → grant=0, tx=1. Assert reset_n mid-OWN → tx=1, grant=0 immediately (asynchronous).
